// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared definitions for the decode/scoreboard stage: IR field
//               offsets, opcode map, opcode-class table, CC encodings and the
//               control-flow FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Instruction and PC widths
    localparam int unsigned c_pc_width  = 32;
    localparam int unsigned c_ir_width  = 32;

    // IR field LSB positions (scalar and vector forms share the word)
    localparam int unsigned c_op_lsb    = 24;
    localparam int unsigned c_dest_lsb  = 20;
    localparam int unsigned c_src1_lsb  = 16;
    localparam int unsigned c_src2_lsb  = 8;
    localparam int unsigned c_vdest_lsb = 16;
    localparam int unsigned c_vsrc1_lsb = 8;
    localparam int unsigned c_vsrc2_lsb = 0;
    localparam int unsigned c_idx_lsb   = 8;
    localparam int unsigned c_imm_lsb   = 0;

    // Condition-code encodings {N,Z,P}
    localparam logic [2:0] c_cc_n     = 3'b100;
    localparam logic [2:0] c_cc_z     = 3'b010;
    localparam logic [2:0] c_cc_p     = 3'b001;
    localparam logic [2:0] c_cc_reset = c_cc_z;

    // Opcode map
    localparam logic [7:0] c_op_nop  = 8'h00;
    localparam logic [7:0] c_op_add  = 8'h01;
    localparam logic [7:0] c_op_addi = 8'h02;
    localparam logic [7:0] c_op_vadd = 8'h10;
    localparam logic [7:0] c_op_cmp  = 8'h20;
    localparam logic [7:0] c_op_brz  = 8'h30;
    localparam logic [7:0] c_op_jmp  = 8'h31;

    // Which resources an opcode reads and writes
    typedef struct packed {
        logic rd_s1;
        logic rd_s2;
        logic rd_v1;
        logic rd_v2;
        logic wr_s;
        logic wr_v;
        logic wr_cc;
        logic rd_cc;
        logic is_br;
    } op_class_t;

    // Control-flow FSM
    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_BR_WAIT = 1'b1
    } de_state_e;

    // Opcode -> resource class; unknown opcodes behave as NOP
    function automatic op_class_t f_op_class(input logic [7:0] op);
        op_class_t cls;
        cls = '0;
        case (op)
            c_op_add:  begin cls.rd_s1 = 1'b1; cls.rd_s2 = 1'b1; cls.wr_s = 1'b1; end
            c_op_addi: begin cls.rd_s1 = 1'b1; cls.wr_s = 1'b1; end
            c_op_vadd: begin cls.rd_v1 = 1'b1; cls.rd_v2 = 1'b1; cls.wr_v = 1'b1; end
            c_op_cmp:  begin cls.rd_s1 = 1'b1; cls.rd_s2 = 1'b1; cls.wr_cc = 1'b1; end
            c_op_brz:  begin cls.rd_cc = 1'b1; cls.is_br = 1'b1; end
            c_op_jmp:  begin cls.rd_s1 = 1'b1; cls.is_br = 1'b1; end
            default:   cls = '0;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_scoreboard_stage_sb_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : sb_counter_bank
// Description : Bank of N saturating pending-write counters. One increment
//               and one decrement port per cycle. busy/full are reported on
//               the post-decrement value so a same-cycle writeback unblocks.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_counter_bank #(
    parameter int N     = 16,
    parameter int CNT_W = 2,
    localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inc_en_i,
    input  logic [IW-1:0] inc_idx_i,
    input  logic          dec_en_i,
    input  logic [IW-1:0] dec_idx_i,
    output logic [N-1:0]  busy_o,
    output logic [N-1:0]  full_o
);

    localparam logic [CNT_W-1:0] c_max = '1;

    for (genvar i = 0; i < N; i++) begin : g_entry
        logic             w_inc_hit;
        logic             w_dec_hit;
        logic             w_dec_ok;
        logic [CNT_W-1:0] w_eff;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        assign w_inc_hit = inc_en_i && (inc_idx_i == IW'(i));
        assign w_dec_hit = dec_en_i && (dec_idx_i == IW'(i));
        // A decrement on an empty counter is dropped so the count never wraps
        assign w_dec_ok  = w_dec_hit && (cnt_q != '0);
        assign w_eff     = cnt_q - CNT_W'(w_dec_ok);
        assign busy_o[i] = (w_eff != '0);
        assign full_o[i] = (w_eff == c_max);

        // Next count: inc and dec on the same entry cancel; saturate at max
        always_comb begin
            cnt_d = cnt_q;
            if (w_inc_hit && !w_dec_ok) begin
                if (cnt_q != c_max) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (!w_inc_hit && w_dec_ok) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        // Counter register
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(w_dec_hit && (cnt_q == '0)));
    end

endmodule
`default_nettype wire

// File: rtl/decode_scoreboard_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_scoreboard_stage
// Description : Decode / register-read stage. Holds scalar RF, vector RF and
//               CC, tracks in-flight writes with pending counters, and issues
//               one instruction per cycle into a valid/ready output slice.
//               Stalls on RAW/CC hazards and while control flow is unresolved.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_scoreboard_stage
    import decode_pkg::*;
#(
    parameter int REG_WIDTH    = 16,
    parameter int NUM_RF       = 16,
    parameter int VLANES       = 4,
    parameter int NUM_VRF      = 64,
    parameter int CNT_W        = 2,
    localparam int RF_IW       = $clog2(NUM_RF),
    localparam int VRF_IW      = $clog2(NUM_VRF),
    localparam int VREG_WIDTH  = VLANES * REG_WIDTH,
    localparam int LANE_IW     = (VLANES > 1) ? $clog2(VLANES) : 1
) (
    input  logic                   I_CLOCK,
    input  logic                   I_RESET_N,
    input  logic                   I_FE_Valid,
    input  logic [c_pc_width-1:0]  I_PC,
    input  logic [c_ir_width-1:0]  I_IR,
    output logic                   O_FE_Ready,
    input  logic                   I_WB_RegWEn,
    input  logic [RF_IW-1:0]       I_WB_RegIdx,
    input  logic [REG_WIDTH-1:0]   I_WB_Data,
    input  logic                   I_WB_VRegWEn,
    input  logic [VRF_IW-1:0]      I_WB_VRegIdx,
    input  logic [VREG_WIDTH-1:0]  I_WB_VData,
    input  logic                   I_WB_CCWEn,
    input  logic [2:0]             I_WB_CC,
    input  logic                   I_WB_BrDone,
    input  logic                   I_EX_Ready,
    output logic                   O_DE_Valid,
    output logic [c_pc_width-1:0]  O_PC,
    output logic [c_ir_width-1:0]  O_IR,
    output logic [7:0]             O_Opcode,
    output logic [RF_IW-1:0]       O_DestRegIdx,
    output logic [VRF_IW-1:0]      O_DestVRegIdx,
    output logic [REG_WIDTH-1:0]   O_Src1Value,
    output logic [REG_WIDTH-1:0]   O_Src2Value,
    output logic [VREG_WIDTH-1:0]  O_VecSrc1Value,
    output logic [VREG_WIDTH-1:0]  O_VecSrc2Value,
    output logic [LANE_IW-1:0]     O_Idx,
    output logic [REG_WIDTH-1:0]   O_Imm,
    output logic [2:0]             O_CCValue,
    output logic                   O_DepStallSignal,
    output logic                   O_BranchStallSignal
);

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [REG_WIDTH-1:0]  rf_q  [NUM_RF];
    logic [VREG_WIDTH-1:0] vrf_q [NUM_VRF];
    logic [2:0]            cc_q;
    de_state_e             state_q;
    de_state_e             state_d;

    // Output slice registers
    logic                  de_valid_q;
    logic [c_pc_width-1:0] pc_q;
    logic [c_ir_width-1:0] ir_q;
    logic [7:0]            opcode_q;
    logic [RF_IW-1:0]      dest_q;
    logic [VRF_IW-1:0]     vdest_q;
    logic [REG_WIDTH-1:0]  src1_q;
    logic [REG_WIDTH-1:0]  src2_q;
    logic [VREG_WIDTH-1:0] vsrc1_q;
    logic [VREG_WIDTH-1:0] vsrc2_q;
    logic [LANE_IW-1:0]    idx_q;
    logic [REG_WIDTH-1:0]  imm_q;
    logic [2:0]            outcc_q;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [7:0]            w_op;
    op_class_t             w_cls;
    logic [RF_IW-1:0]      w_dest;
    logic [RF_IW-1:0]      w_src1;
    logic [RF_IW-1:0]      w_src2;
    logic [VRF_IW-1:0]     w_vdest;
    logic [VRF_IW-1:0]     w_vsrc1;
    logic [VRF_IW-1:0]     w_vsrc2;
    logic [LANE_IW-1:0]    w_idx;
    logic [REG_WIDTH-1:0]  w_imm;

    assign w_op    = I_IR[c_op_lsb +: 8];
    assign w_cls   = f_op_class(w_op);
    assign w_dest  = I_IR[c_dest_lsb  +: RF_IW];
    assign w_src1  = I_IR[c_src1_lsb  +: RF_IW];
    assign w_src2  = I_IR[c_src2_lsb  +: RF_IW];
    assign w_vdest = I_IR[c_vdest_lsb +: VRF_IW];
    assign w_vsrc1 = I_IR[c_vsrc1_lsb +: VRF_IW];
    assign w_vsrc2 = I_IR[c_vsrc2_lsb +: VRF_IW];
    assign w_idx   = I_IR[c_idx_lsb   +: LANE_IW];
    assign w_imm   = REG_WIDTH'($signed(I_IR[c_imm_lsb +: 16]));

    // ------------------------------------------------------------------
    // Operand read with same-cycle writeback bypass
    // ------------------------------------------------------------------
    logic [REG_WIDTH-1:0]  w_src1_val;
    logic [REG_WIDTH-1:0]  w_src2_val;
    logic [VREG_WIDTH-1:0] w_vsrc1_val;
    logic [VREG_WIDTH-1:0] w_vsrc2_val;
    logic [2:0]            w_cc_val;

    assign w_src1_val  = (I_WB_RegWEn  && (I_WB_RegIdx  == w_src1))  ? I_WB_Data  : rf_q[w_src1];
    assign w_src2_val  = (I_WB_RegWEn  && (I_WB_RegIdx  == w_src2))  ? I_WB_Data  : rf_q[w_src2];
    assign w_vsrc1_val = (I_WB_VRegWEn && (I_WB_VRegIdx == w_vsrc1)) ? I_WB_VData : vrf_q[w_vsrc1];
    assign w_vsrc2_val = (I_WB_VRegWEn && (I_WB_VRegIdx == w_vsrc2)) ? I_WB_VData : vrf_q[w_vsrc2];
    assign w_cc_val    = I_WB_CCWEn ? I_WB_CC : cc_q;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [NUM_RF-1:0]  w_rf_busy;
    logic [NUM_RF-1:0]  w_rf_full;
    logic [NUM_VRF-1:0] w_vrf_busy;
    logic [NUM_VRF-1:0] w_vrf_full;
    logic [0:0]         w_cc_busy;
    logic [0:0]         w_cc_full;
    logic               w_hazard;
    logic               w_issue;

    sb_counter_bank #(.N(NUM_RF), .CNT_W(CNT_W)) u_rf_cnt (
        .clk_i     (I_CLOCK),
        .rst_ni    (I_RESET_N),
        .inc_en_i  (w_issue && w_cls.wr_s),
        .inc_idx_i (w_dest),
        .dec_en_i  (I_WB_RegWEn),
        .dec_idx_i (I_WB_RegIdx),
        .busy_o    (w_rf_busy),
        .full_o    (w_rf_full)
    );

    sb_counter_bank #(.N(NUM_VRF), .CNT_W(CNT_W)) u_vrf_cnt (
        .clk_i     (I_CLOCK),
        .rst_ni    (I_RESET_N),
        .inc_en_i  (w_issue && w_cls.wr_v),
        .inc_idx_i (w_vdest),
        .dec_en_i  (I_WB_VRegWEn),
        .dec_idx_i (I_WB_VRegIdx),
        .busy_o    (w_vrf_busy),
        .full_o    (w_vrf_full)
    );

    sb_counter_bank #(.N(1), .CNT_W(CNT_W)) u_cc_cnt (
        .clk_i     (I_CLOCK),
        .rst_ni    (I_RESET_N),
        .inc_en_i  (w_issue && w_cls.wr_cc),
        .inc_idx_i (1'b0),
        .dec_en_i  (I_WB_CCWEn),
        .dec_idx_i (1'b0),
        .busy_o    (w_cc_busy),
        .full_o    (w_cc_full)
    );

    // A read of a pending register, or a write to a saturated counter, blocks issue
    assign w_hazard = (w_cls.rd_s1 && w_rf_busy[w_src1])
                   || (w_cls.rd_s2 && w_rf_busy[w_src2])
                   || (w_cls.rd_v1 && w_vrf_busy[w_vsrc1])
                   || (w_cls.rd_v2 && w_vrf_busy[w_vsrc2])
                   || (w_cls.rd_cc && w_cc_busy[0])
                   || (w_cls.wr_s  && w_rf_full[w_dest])
                   || (w_cls.wr_v  && w_vrf_full[w_vdest])
                   || (w_cls.wr_cc && w_cc_full[0]);

    assign w_issue = I_FE_Valid && (state_q == ST_RUN) && !w_hazard
                  && (!de_valid_q || I_EX_Ready);

    assign O_FE_Ready          = w_issue;
    assign O_DepStallSignal    = I_FE_Valid && w_hazard && (state_q == ST_RUN);
    assign O_BranchStallSignal = (state_q == ST_BR_WAIT) || (I_FE_Valid && w_cls.is_br);

    // ------------------------------------------------------------------
    // Register files and CC
    // ------------------------------------------------------------------

    // Scalar RF writeback
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            for (int i = 0; i < NUM_RF; i++) begin
                rf_q[i] <= '0;
            end
        end else if (I_WB_RegWEn) begin
            rf_q[I_WB_RegIdx] <= I_WB_Data;
        end
    end

    // Vector RF writeback
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            for (int i = 0; i < NUM_VRF; i++) begin
                vrf_q[i] <= '0;
            end
        end else if (I_WB_VRegWEn) begin
            vrf_q[I_WB_VRegIdx] <= I_WB_VData;
        end
    end

    // Condition-code writeback
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            cc_q <= c_cc_reset;
        end else if (I_WB_CCWEn) begin
            cc_q <= I_WB_CC;
        end
    end

    // ------------------------------------------------------------------
    // Control-flow FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Enter BR_WAIT on branch issue; leave on resolution (ignored while running)
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (w_issue && w_cls.is_br) state_d = ST_BR_WAIT;
            ST_BR_WAIT: if (I_WB_BrDone)            state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Output slice: load on issue, hold under backpressure, drain otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            de_valid_q <= 1'b0;
            pc_q       <= '0;
            ir_q       <= '0;
            opcode_q   <= '0;
            dest_q     <= '0;
            vdest_q    <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            vsrc1_q    <= '0;
            vsrc2_q    <= '0;
            idx_q      <= '0;
            imm_q      <= '0;
            outcc_q    <= '0;
        end else if (w_issue) begin
            de_valid_q <= 1'b1;
            pc_q       <= I_PC;
            ir_q       <= I_IR;
            opcode_q   <= w_op;
            dest_q     <= w_dest;
            vdest_q    <= w_vdest;
            src1_q     <= w_src1_val;
            src2_q     <= w_src2_val;
            vsrc1_q    <= w_vsrc1_val;
            vsrc2_q    <= w_vsrc2_val;
            idx_q      <= w_idx;
            imm_q      <= w_imm;
            outcc_q    <= w_cc_val;
        end else if (I_EX_Ready) begin
            de_valid_q <= 1'b0;
        end
    end

    assign O_DE_Valid     = de_valid_q;
    assign O_PC           = pc_q;
    assign O_IR           = ir_q;
    assign O_Opcode       = opcode_q;
    assign O_DestRegIdx   = dest_q;
    assign O_DestVRegIdx  = vdest_q;
    assign O_Src1Value    = src1_q;
    assign O_Src2Value    = src2_q;
    assign O_VecSrc1Value = vsrc1_q;
    assign O_VecSrc2Value = vsrc2_q;
    assign O_Idx          = idx_q;
    assign O_Imm          = imm_q;
    assign O_CCValue      = outcc_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_scoreboard_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_scoreboard_stage
// Description : Directed self-checking bench for decode_scoreboard_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_scoreboard_stage;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_ADDI = 8'h02;
    localparam logic [7:0] OP_VADD = 8'h10;
    localparam logic [7:0] OP_CMP  = 8'h20;
    localparam logic [7:0] OP_BRZ  = 8'h30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fe_valid;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        fe_ready;
    logic        wb_we;
    logic [3:0]  wb_idx;
    logic [15:0] wb_data;
    logic        wb_vwe;
    logic [5:0]  wb_vidx;
    logic [63:0] wb_vdata;
    logic        wb_ccwe;
    logic [2:0]  wb_cc;
    logic        wb_brdone;
    logic        ex_ready;
    logic        de_valid;
    logic [31:0] o_pc;
    logic [31:0] o_ir;
    logic [7:0]  o_op;
    logic [3:0]  o_dest;
    logic [5:0]  o_vdest;
    logic [15:0] o_s1;
    logic [15:0] o_s2;
    logic [63:0] o_v1;
    logic [63:0] o_v2;
    logic [1:0]  o_idx;
    logic [15:0] o_imm;
    logic [2:0]  o_cc;
    logic        dep_stall;
    logic        br_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_scoreboard_stage dut (
        .I_CLOCK             (clk),
        .I_RESET_N           (rst_n),
        .I_FE_Valid          (fe_valid),
        .I_PC                (pc),
        .I_IR                (ir),
        .O_FE_Ready          (fe_ready),
        .I_WB_RegWEn         (wb_we),
        .I_WB_RegIdx         (wb_idx),
        .I_WB_Data           (wb_data),
        .I_WB_VRegWEn        (wb_vwe),
        .I_WB_VRegIdx        (wb_vidx),
        .I_WB_VData          (wb_vdata),
        .I_WB_CCWEn          (wb_ccwe),
        .I_WB_CC             (wb_cc),
        .I_WB_BrDone         (wb_brdone),
        .I_EX_Ready          (ex_ready),
        .O_DE_Valid          (de_valid),
        .O_PC                (o_pc),
        .O_IR                (o_ir),
        .O_Opcode            (o_op),
        .O_DestRegIdx        (o_dest),
        .O_DestVRegIdx       (o_vdest),
        .O_Src1Value         (o_s1),
        .O_Src2Value         (o_s2),
        .O_VecSrc1Value      (o_v1),
        .O_VecSrc2Value      (o_v2),
        .O_Idx               (o_idx),
        .O_Imm               (o_imm),
        .O_CCValue           (o_cc),
        .O_DepStallSignal    (dep_stall),
        .O_BranchStallSignal (br_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_wb();
        wb_we = 1'b0; wb_vwe = 1'b0; wb_ccwe = 1'b0; wb_brdone = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] p, input logic [31:0] i);
        fe_valid = 1'b1; pc = p; ir = i;
    endtask

    function automatic logic [31:0] ir_rrr(input logic [7:0] op, input logic [3:0] d,
                                           input logic [3:0] s1, input logic [3:0] s2);
        return {op, d, s1, 4'h0, s2, 8'h00};
    endfunction

    function automatic logic [31:0] ir_ri(input logic [7:0] op, input logic [3:0] d,
                                          input logic [3:0] s1, input logic [15:0] imm);
        return {op, d, s1, imm};
    endfunction

    function automatic logic [31:0] ir_vvv(input logic [7:0] op, input logic [5:0] vd,
                                           input logic [5:0] vs1, input logic [5:0] vs2);
        return {op, 2'b00, vd, 2'b00, vs1, 2'b00, vs2};
    endfunction

    initial begin
        // ---------------- reset ----------------
        rst_n = 1'b0; fe_valid = 1'b0; pc = '0; ir = '0; ex_ready = 1'b1;
        wb_idx = '0; wb_data = '0; wb_vidx = '0; wb_vdata = '0; wb_cc = '0;
        clr_wb();
        tick(); tick();
        chk("rst_de_valid", de_valid, 0);
        chk("rst_pc", o_pc, 0);
        chk("rst_cc_out", o_cc, 0);
        chk("rst_fe_ready", fe_ready, 0);
        chk("rst_br_stall", br_stall, 0);
        chk("rst_dep_stall", dep_stall, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- prime R2/R3 via writers + writeback ----------------
        fetch(32'h100, ir_ri(OP_ADDI, 4'd2, 4'd0, 16'h0005));
        #1 chk("addi2_ready", fe_ready, 1);
        tick();
        chk("addi2_valid", de_valid, 1);
        chk("addi2_pc", o_pc, 32'h100);
        chk("addi2_op", o_op, OP_ADDI);
        chk("addi2_dest", o_dest, 2);
        chk("addi2_imm", o_imm, 16'h0005);
        chk("addi2_cc_reset", o_cc, 3'b010);

        fetch(32'h104, ir_ri(OP_ADDI, 4'd3, 4'd0, 16'hFFF0));
        #1 chk("addi3_ready", fe_ready, 1);
        tick();
        chk("addi3_dest", o_dest, 3);
        chk("addi3_imm", o_imm, 16'hFFF0);

        fe_valid = 1'b0; wb_we = 1'b1; wb_idx = 4'd2; wb_data = 16'h1234;
        tick();
        chk("drain_valid", de_valid, 0);
        wb_idx = 4'd3; wb_data = 16'h00AB;
        tick();
        clr_wb();

        // ---------------- ADD R1,R2,R3 ----------------
        fetch(32'h108, ir_rrr(OP_ADD, 4'd1, 4'd2, 4'd3));
        #1 chk("add1_ready", fe_ready, 1);
        tick();
        chk("add1_valid", de_valid, 1);
        chk("add1_src1", o_s1, 16'h1234);
        chk("add1_src2", o_s2, 16'h00AB);
        chk("add1_dest", o_dest, 1);

        // ---------------- ADDI R4<-R1 with same-cycle WB R1 ----------------
        fetch(32'h10C, ir_ri(OP_ADDI, 4'd4, 4'd1, 16'h0001));
        wb_we = 1'b1; wb_idx = 4'd1; wb_data = 16'h0007;
        #1 chk("addi4_ready_bypass", fe_ready, 1);
        chk("addi4_nodep", dep_stall, 0);
        tick();
        clr_wb();
        chk("addi4_src1_bypass", o_s1, 16'h0007);
        chk("addi4_dest", o_dest, 4);

        // ---------------- ADD R5<-R4,R4 stalls until WB R4 ----------------
        fetch(32'h110, ir_rrr(OP_ADD, 4'd5, 4'd4, 4'd4));
        for (int k = 0; k < 2; k++) begin
            #1 chk("add5_stall_ready", fe_ready, 0);
            chk("add5_stall_dep", dep_stall, 1);
            tick();
            chk("add5_stall_valid", de_valid, 0);
        end
        wb_we = 1'b1; wb_idx = 4'd4; wb_data = 16'h0010;
        #1 chk("add5_release_ready", fe_ready, 1);
        chk("add5_release_dep", dep_stall, 0);
        tick();
        clr_wb();
        chk("add5_valid", de_valid, 1);
        chk("add5_src1", o_s1, 16'h0010);
        chk("add5_src2", o_s2, 16'h0010);
        chk("add5_dest", o_dest, 5);

        // ---------------- three writers to R6, fourth stalls ----------------
        for (int k = 0; k < 3; k++) begin
            fetch(32'h120 + 32'(4 * k), ir_ri(OP_ADDI, 4'd6, 4'd0, 16'(k)));
            #1 chk("r6_writer_ready", fe_ready, 1);
            tick();
        end
        fetch(32'h12C, ir_ri(OP_ADDI, 4'd6, 4'd0, 16'h0003));
        #1 chk("r6_full_ready", fe_ready, 0);
        chk("r6_full_dep", dep_stall, 1);
        tick();
        fe_valid = 1'b0;
        #1 chk("r6_fe_invalid_dep", dep_stall, 0);
        tick();
        fe_valid = 1'b1;
        wb_we = 1'b1; wb_idx = 4'd6; wb_data = 16'h0666;
        #1 chk("r6_wb_ready", fe_ready, 1);
        tick();
        clr_wb();
        chk("r6_fourth_valid", de_valid, 1);
        chk("r6_fourth_pc", o_pc, 32'h12C);

        // ---------------- vector read with same-cycle vector WB ----------------
        fetch(32'h140, ir_vvv(OP_VADD, 6'd1, 6'd0, 6'd0));
        #1 chk("vadd1_ready", fe_ready, 1);
        tick();
        fetch(32'h144, ir_vvv(OP_VADD, 6'd5, 6'd1, 6'd2));
        wb_vwe = 1'b1; wb_vidx = 6'd1; wb_vdata = 64'h1111_2222_3333_4444;
        #1 chk("vadd5_ready_bypass", fe_ready, 1);
        tick();
        clr_wb();
        chk("vadd5_vsrc1", o_v1, 64'h1111_2222_3333_4444);
        chk("vadd5_vsrc2", o_v2, 64'h0);
        chk("vadd5_vdest", o_vdest, 5);
        chk("vadd5_idx", o_idx, 2'd1);

        // ---------------- CMP then BRZ: CC hazard then branch wait ----------------
        fetch(32'h200, ir_rrr(OP_CMP, 4'd0, 4'd0, 4'd0));
        #1 chk("cmp_ready", fe_ready, 1);
        tick();
        fetch(32'h204, {OP_BRZ, 24'h0});
        #1 chk("brz_cc_ready", fe_ready, 0);
        chk("brz_cc_dep", dep_stall, 1);
        chk("brz_cc_brstall", br_stall, 1);
        tick();
        wb_ccwe = 1'b1; wb_cc = 3'b100;
        #1 chk("brz_issue_ready", fe_ready, 1);
        tick();
        clr_wb();
        chk("brz_valid", de_valid, 1);
        chk("brz_op", o_op, OP_BRZ);
        chk("brz_cc_bypass", o_cc, 3'b100);

        fetch(32'h208, ir_rrr(OP_ADD, 4'd7, 4'd0, 4'd0));
        for (int k = 0; k < 5; k++) begin
            #1 chk("brwait_ready", fe_ready, 0);
            chk("brwait_brstall", br_stall, 1);
            tick();
        end
        chk("brwait_drained", de_valid, 0);
        wb_brdone = 1'b1;
        #1 chk("brdone_cycle_ready", fe_ready, 0);
        tick();
        clr_wb();
        #1 chk("after_br_ready", fe_ready, 1);
        chk("after_br_brstall", br_stall, 0);
        tick();
        chk("after_br_pc", o_pc, 32'h208);
        chk("after_br_dest", o_dest, 7);

        // BrDone while running has no effect
        fetch(32'h20C, ir_rrr(OP_ADD, 4'd8, 4'd0, 4'd0));
        wb_brdone = 1'b1;
        tick();
        clr_wb();
        fetch(32'h210, ir_rrr(OP_ADD, 4'd9, 4'd0, 4'd0));
        #1 chk("run_brdone_ignored", fe_ready, 1);
        tick();

        // ---------------- EX backpressure ----------------
        fetch(32'h300, ir_rrr(OP_ADD, 4'd10, 4'd0, 4'd0));
        tick();
        ex_ready = 1'b0;
        fetch(32'h304, ir_rrr(OP_ADD, 4'd11, 4'd0, 4'd0));
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_ready", fe_ready, 0);
            tick();
            chk("bp_valid", de_valid, 1);
            chk("bp_pc_hold", o_pc, 32'h300);
            chk("bp_dest_hold", o_dest, 10);
        end
        ex_ready = 1'b1;
        #1 chk("bp_release_ready", fe_ready, 1);
        tick();
        chk("bp_release_pc", o_pc, 32'h304);
        chk("bp_release_dest", o_dest, 11);

        // ---------------- reset mid-operation in BR_WAIT ----------------
        fetch(32'h400, {OP_BRZ, 24'h0});
        tick();
        fe_valid = 1'b0;
        #1 chk("pre_rst_brstall", br_stall, 1);
        #1 rst_n = 1'b0;
        #1 chk("midrst_valid", de_valid, 0);
        chk("midrst_pc", o_pc, 0);
        chk("midrst_src1", o_s1, 0);
        chk("midrst_brstall", br_stall, 0);
        tick();
        rst_n = 1'b1;
        fetch(32'h500, ir_rrr(OP_ADD, 4'd12, 4'd6, 4'd5));
        #1 chk("postrst_ready", fe_ready, 1);
        chk("postrst_dep", dep_stall, 0);
        chk("postrst_brstall", br_stall, 0);
        tick();
        chk("postrst_src1", o_s1, 0);
        chk("postrst_src2", o_s2, 0);
        chk("postrst_cc", o_cc, 3'b010);
        fetch(32'h504, ir_rrr(OP_ADD, 4'd13, 4'd2, 4'd3));
        tick();
        chk("postrst_rf_cleared", o_s1, 0);
        fe_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
